mem_access_unit: RTL
====================

# mem_access_unit

Initiator-side memory access unit for the pipeline's MEM stage. It accepts one load/store request at a time from the pipeline, drives the data memory's `memRead`/`memWrite`/`addr`/`writeData` port, waits a parameterised memory latency, and returns read data or completion. Byte stores are built as read-modify-write sequences, so the memory only ever sees word accesses. Byte loads are extracted and zero-extended locally.

## Interface
- `LAT`, default 1: memory access latency in cycles. Legal range 1..15. Each strobe is held for `LAT` cycles.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the unit can accept a request; high only in IDLE.
- `req_memRead` in 2: `01` word load, `10` byte load, `00` none.
- `req_memWrite` in 2: `01` word store, `10` byte store, `00` none.
- `req_addr` in 16: byte address.
- `req_wdata` in 16: store data. Byte stores use `[7:0]`.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 16: load result. It is 0 for stores and errors.
- `rsp_err` out 1: the request was illegal. Qualified by `rsp_valid`.
- `memRead` out 2: to data memory. Only `00` or `01` is ever driven.
- `memWrite` out 2: to data memory. Only `00` or `01` is ever driven.
- `addr` out 16: word-aligned address, always `{req_addr[15:1],1'b0}`.
- `writeData` out 16: word written to memory.
- `readData` in 16: from data memory. Valid at the end of the `LAT`th read cycle.
- `busy` out 1: equals `!req_ready`. The pipeline stalls on it.

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- Accept: `req_valid && req_ready` at a clock edge. The unit then registers the request, the lane (`req_addr[0]`) and the data.
- Legality:
  - An error occurs if both codes are nonzero, if either code is `11`, or if both codes are `00`.
  - A word access with `req_addr[0]=1` is misaligned and is also an error.
  - An error goes straight to RESP with `rsp_err=1`. No memory strobe is issued.
- Word load or byte load: IDLE→RD. After `LAT` cycles, `readData` is captured and the unit goes to RESP.
  - Byte-load lane: lane 0 returns `{8'h00, readData[7:0]}`. Lane 1 returns `{8'h00, readData[15:8]}`.
- Word store: IDLE→WR. `writeData=req_wdata` for `LAT` cycles, then RESP.
- Byte store: IDLE→RMW_RD for `LAT` cycles. The read word is captured and merged, then RMW_WR for `LAT` cycles, then RESP.
  - Lane 0 writes `{old[15:8], wdata[7:0]}`.
  - Lane 1 writes `{wdata[7:0], old[7:0]}`.
- RESP: `rsp_valid=1` for exactly one cycle, then IDLE. A request arriving during RESP is not accepted; it is held by the requester.
- Latency counter: 4 bits. It loads `LAT-1` on state entry, counts down, and the unit exits the state at 0.
- `memRead`/`memWrite`/`addr`/`writeData` are registered outputs. They are `00`/0 in IDLE and RESP.

## Timing
- Reset values: `req_ready=1`, `busy=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `memRead=00`, `memWrite=00`, `addr=0`, `writeData=0`. State is IDLE.
- Cycle numbering: a request is accepted at the edge ending cycle 0.
  - Load or word store: strobes are high in cycles 1..LAT, and `rsp_valid` is high in cycle LAT+1.
  - Byte store: `memRead` is high in cycles 1..LAT, `memWrite` in cycles LAT+1..2LAT, and `rsp_valid` in cycle 2LAT+1.
  - Error: `rsp_valid` is high in cycle 1.
- Throughput: one request per LAT+2 cycles (2LAT+2 for a byte store), or per 2 cycles for errors.
- `memRead` and `memWrite` are never both nonzero in the same cycle. RMW_RD→RMW_WR is a direct transition with no idle cycle.
- Reset mid-operation: all strobes are `00` from the cycle after the `rst` edge. A pending RMW write is never issued, no `rsp_valid` is produced for the aborted request, and `req_ready=1` on the first cycle with `rst` low.
- Request inputs are ignored whenever `req_ready=0`.

## Structure
- Shared package `mem_pkg` holds:
  - the access-code constants `MEM_NONE=2'b00`, `MEM_WORD=2'b01`, `MEM_BYTE=2'b10`;
  - the state enum;
  - the `LAT` range limit.
- One natural sub-module, `byte_lane`: purely combinational. It performs byte extract with zero-extend, and the store merge selected by lane.
- FSM, latency counter and output registers live in `mem_access_unit`.

## Test plan
Memory is preloaded with `0x0000`=`3142`, `0x0004`=`5678`, `0x0006`=`DEAD`.

- Word load, `LAT=1`, addr `0x0006`: `memRead=01` and `addr=0006` in cycle 1; `rsp_valid` in cycle 2 with `rsp_rdata=DEAD` and `rsp_err=0`.
- Byte loads: addr `0x0007` → `rsp_rdata=00DE`; addr `0x0006` → `00AD`. In both cases `addr` is driven as `0006`.
- Byte store, `LAT=1`, addr `0x0001`, wdata `0x00AB`:
  - cycle 1: `memRead=01` at `addr=0000`;
  - cycle 2: `memWrite=01` with `writeData=AB42`;
  - cycle 3: `rsp_valid`;
  - memory `0x0000` now reads `AB42`.
- Illegal requests: misaligned word load at `0x0005`, or `memRead=01` together with `memWrite=01`. In each case `rsp_valid` and `rsp_err` are high in cycle 1, and `memRead`/`memWrite` stay `00` throughout.
- `LAT=3`, back-to-back word stores to `0x0004` (`1111`) then `0x0002` (`2222`): each `memWrite` is held 3 cycles, `busy` is high for 4 cycles per request, and the second request is accepted on the cycle after the first `rsp_valid`.
- `rst` asserted in cycle 1 of a byte store: `memRead=00` from cycle 2, no `memWrite` ever issued, memory unchanged, `req_ready=1` after `rst` is released.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared access codes, FSM states and latency limit for the memory access unit
package mem_pkg;
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_WORD = 2'b01;
  localparam logic [1:0] MEM_BYTE = 2'b10;
  localparam int LAT_MAX = 15;
  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;
  function automatic logic req_illegal(logic [1:0] rd, logic [1:0] wr, logic a0);
    return (rd != MEM_NONE && wr != MEM_NONE) || rd == 2'b11 || wr == 2'b11 ||
           (rd == MEM_NONE && wr == MEM_NONE) || ((rd == MEM_WORD || wr == MEM_WORD) && a0);
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response and data memory port bundle
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_memRead;
  logic [1:0]  req_memWrite;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  memRead;
  logic [1:0]  memWrite;
  logic [15:0] addr;
  logic [15:0] writeData;
  logic [15:0] readData;
  logic        busy;
  modport slave (
    input  req_valid, req_memRead, req_memWrite, req_addr, req_wdata, readData,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, memRead, memWrite, addr, writeData, busy
  );
  modport master (
    output req_valid, req_memRead, req_memWrite, req_addr, req_wdata, readData,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, memRead, memWrite, addr, writeData, busy
  );
endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// byte_lane: byte extract with zero-extend and byte merge into a word, selected by lane
module byte_lane (
  input  logic        lane_i,
  input  logic [15:0] word_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] ext_o,
  output logic [15:0] merge_o
);
  assign ext_o   = {8'h00, lane_i ? word_i[15:8] : word_i[7:0]};
  assign merge_o = lane_i ? {byte_i, word_i[7:0]} : {word_i[15:8], byte_i};
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator with byte RMW stores and fixed memory latency
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int LAT = 1
) (
  input logic clk,
  input logic rst,
  mem_access_unit_if.slave bus
);
  localparam int L = LAT < 1 ? 1 : (LAT > LAT_MAX ? LAT_MAX : LAT);
  localparam logic [3:0] CNT_INIT = 4'(L - 1);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        lane_q, lane_d, byte_q, byte_d, err_q, err_d;
  logic [15:0] a_q, a_d, wd_q, wd_d, rdata_q, rdata_d;
  logic [1:0]  mr_q, mr_d, mw_q, mw_d;
  logic [15:0] addr_q, addr_d, wrd_q, wrd_d;
  logic        accept, done, illegal;
  logic [15:0] ext, merged;
  byte_lane u_lane (
    .lane_i (lane_q),
    .word_i (bus.readData),
    .byte_i (wd_q[7:0]),
    .ext_o  (ext),
    .merge_o(merged)
  );
  assign accept  = bus.req_valid && state_q == IDLE;
  assign done    = cnt_q == 4'd0;
  assign illegal = req_illegal(bus.req_memRead, bus.req_memWrite, bus.req_addr[0]);
  assign bus.req_ready = state_q == IDLE;
  assign bus.busy      = state_q != IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_err   = state_q == RESP && err_q;
  assign bus.rsp_rdata = state_q == RESP ? rdata_q : 16'h0000;
  assign bus.memRead   = mr_q;
  assign bus.memWrite  = mw_q;
  assign bus.addr      = addr_q;
  assign bus.writeData = wrd_q;
  // next state, latency countdown, request capture; strobes are derived from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    byte_d  = byte_q;
    err_d   = err_q;
    a_d     = a_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        lane_d  = bus.req_addr[0];
        byte_d  = bus.req_memRead == MEM_BYTE;
        err_d   = illegal;
        a_d     = {bus.req_addr[15:1], 1'b0};
        wd_d    = bus.req_wdata;
        rdata_d = 16'h0000;
        cnt_d   = CNT_INIT;
        state_d = illegal ? RESP : bus.req_memRead != MEM_NONE ? RD :
                  bus.req_memWrite == MEM_WORD ? WR : RMW_RD;
      end
      RD: if (done) begin
        rdata_d = byte_q ? ext : bus.readData;
        state_d = RESP;
      end else cnt_d = cnt_q - 4'd1;
      RMW_RD: if (done) begin
        wd_d    = merged;
        cnt_d   = CNT_INIT;
        state_d = RMW_WR;
      end else cnt_d = cnt_q - 4'd1;
      WR, RMW_WR: if (done) state_d = RESP;
      else cnt_d = cnt_q - 4'd1;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mr_d   = (state_d == RD || state_d == RMW_RD) ? MEM_WORD : MEM_NONE;
    mw_d   = (state_d == WR || state_d == RMW_WR) ? MEM_WORD : MEM_NONE;
    addr_d = (mr_d != MEM_NONE || mw_d != MEM_NONE) ? a_d : 16'h0000;
    wrd_d  = mw_d != MEM_NONE ? wd_d : 16'h0000;
  end
  // state and registered memory port; reset drops any in-flight access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      lane_q  <= 1'b0;
      byte_q  <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= 16'h0000;
      wd_q    <= 16'h0000;
      rdata_q <= 16'h0000;
      mr_q    <= MEM_NONE;
      mw_q    <= MEM_NONE;
      addr_q  <= 16'h0000;
      wrd_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      addr_q  <= addr_d;
      wrd_q   <= wrd_d;
    end
  end
endmodule
